// File: rtl/relu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : relu_arb_pkg
// Brief   : Shared types, width helper and rectifier function for the
//           ReLU stream arbiter. Optional macro: RELU_LEAKY_EN.
// Rev     : 1.0  initial release
// ============================================================================
package relu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RELU_MAX_W = 64;

`ifdef RELU_LEAKY_EN
    localparam bit RELU_LEAKY = 1'b1;
`else
    localparam bit RELU_LEAKY = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Operand arrives sign-extended to RELU_MAX_W; callers truncate the result.
    function automatic logic signed [RELU_MAX_W-1:0] relu_fn(
        input logic signed [RELU_MAX_W-1:0] x,
        input int unsigned                  shift
    );
        if (!x[RELU_MAX_W-1]) return x;
        return RELU_LEAKY ? (x >>> shift) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : relu_stream_arbiter_if
// Brief     : Requester-side and downstream-side handshake bundle.
// Rev       : 1.0  initial release
// ============================================================================
interface relu_stream_arbiter_if
    import relu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int ID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_last;
    logic                      out_ready;
    logic                      busy;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_id, out_last, busy
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/relu_out_stage.sv
`default_nettype none
// ============================================================================
// Module : relu_out_stage
// Brief  : Single registered output slot; rectifies on load, holds under
//          backpressure. Leaky slope when RELU_LEAKY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module relu_out_stage
    import relu_arb_pkg::*;
#(
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          ID_W       = 2,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              in_valid,
    input  wire logic [DATA_W-1:0] in_data,
    input  wire logic [ID_W-1:0]   in_id,
    input  wire logic              in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_last,
    input  wire logic              out_ready
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              last_q, last_d;

    // A new beat may replace the held one in the same cycle it drains.
    assign in_ready = out_ready | ~valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (in_valid) begin
            valid_d = 1'b1;
            data_d  = DATA_W'(relu_fn(RELU_MAX_W'(signed'(in_data)), LEAK_SHIFT));
            id_d    = in_id;
            last_d  = in_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_last  = last_q;
endmodule
`default_nettype wire

// File: rtl/relu_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : relu_stream_arbiter
// Brief  : Round-robin, burst-locked arbiter feeding one registered ReLU
//          stage. Optional macro: RELU_LEAKY_EN (leaky negative slope).
// Rev    : 1.0  initial release
// ============================================================================
module relu_stream_arbiter
    import relu_arb_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          BURST_LEN  = 16,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    relu_stream_arbiter_if.slave   bus
);
    localparam int ID_W  = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_LEN + 1);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic               w_arb_found;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_slot_ready;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_out_valid;

    // Search starts just past the last winner so every stream gets a turn.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!w_arb_found && bus.req_valid[cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = cand;
            end
        end
    end

    assign w_xfer = (state_q == ST_GRANT) & bus.req_valid[gnt_q] & w_slot_ready;

    always_comb begin
        w_req_ready = '0;
        if (state_q == ST_GRANT) w_req_ready[gnt_q] = w_slot_ready;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_arb_found) begin
                    gnt_d      = w_arb_idx;
                    rr_ptr_d   = w_arb_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (bus.req_last[gnt_q] || beat_cnt_q == CNT_W'(BURST_LEN - 1))
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    relu_out_stage #(
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_xfer),
        .in_data   (bus.req_data[int'(gnt_q)*DATA_W +: DATA_W]),
        .in_id     (gnt_q),
        .in_last   (bus.req_last[gnt_q]),
        .in_ready  (w_slot_ready),
        .out_valid (w_out_valid),
        .out_data  (bus.out_data),
        .out_id    (bus.out_id),
        .out_last  (bus.out_last),
        .out_ready (bus.out_ready)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (state_q == ST_GRANT) | w_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_relu_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_relu_stream_arbiter
// Brief  : Directed bench; dut_a uses BURST_LEN=16, dut_b BURST_LEN=2.
// Rev    : 1.0  initial release
// ============================================================================
module tb_relu_stream_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    relu_stream_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) a_if ();
    relu_stream_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) b_if ();

    relu_stream_arbiter #(.NUM_REQ(4), .DATA_W(32), .BURST_LEN(16), .LEAK_SHIFT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if));
    relu_stream_arbiter #(.NUM_REQ(4), .DATA_W(32), .BURST_LEN(2), .LEAK_SHIFT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] id, input logic l);
        chk({tag, "_valid"}, 64'(a_if.out_valid), 64'(v));
        if (v) begin
            chk({tag, "_data"}, 64'(a_if.out_data), 64'(d));
            chk({tag, "_id"},   64'(a_if.out_id),   64'(id));
            chk({tag, "_last"}, 64'(a_if.out_last), 64'(l));
        end
    endtask

    task automatic drive_a(input logic [3:0] v, input logic [3:0] l, input logic [127:0] d);
        a_if.req_valid = v;
        a_if.req_last  = l;
        a_if.req_data  = d;
    endtask

    function automatic logic [127:0] pk(input logic [31:0] d0, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        drive_a(4'b0, 4'b0, '0);
        a_if.out_ready = 1'b1;
        b_if.req_valid = '0;
        b_if.req_last  = '0;
        b_if.req_data  = '0;
        b_if.out_ready = 1'b1;
        repeat (2) step();

        // Reset state
        chk("rst_valid", 64'(a_if.out_valid), 0);
        chk("rst_data",  64'(a_if.out_data),  0);
        chk("rst_id",    64'(a_if.out_id),    0);
        chk("rst_last",  64'(a_if.out_last),  0);
        chk("rst_ready", 64'(a_if.req_ready), 0);
        chk("rst_busy",  64'(a_if.busy),      0);
        chk("rst_b_busy", 64'(b_if.busy),     0);
        rst_n = 1'b1;

        // 1: single requester 1, three beats
        drive_a(4'b0010, 4'b0000, pk(0, 32'h0000_0005, 0, 0));
        step();
        chk("t1_ready", 64'(a_if.req_ready), 64'(4'b0010));
        chk("t1_nolat", 64'(a_if.out_valid), 0);
        step();
        chk_a("t1_b1", 1, 32'h5, 1, 0);
        drive_a(4'b0010, 4'b0000, pk(0, 32'hFFFF_FFFB, 0, 0));
        step();
        chk_a("t1_b2", 1, 32'h0, 1, 0);
        drive_a(4'b0010, 4'b0010, pk(0, 32'h8000_0000, 0, 0));
        step();
        chk_a("t1_b3", 1, 32'h0, 1, 1);
        drive_a(4'b0, 4'b0, '0);
        step();
        chk_a("t1_drain", 0, 0, 0, 0);
        chk("t1_busy", 64'(a_if.busy), 0);

        // 2: dut_b fairness, 2-beat bursts with bubbles
        b_if.req_valid = 4'b1111;
        b_if.req_data  = pk(32'h100, 32'h101, 32'h102, 32'h103);
        step();
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 2; k++) begin
                step();
                chk($sformatf("t2_v_%0d_%0d", b, k), 64'(b_if.out_valid), 1);
                chk($sformatf("t2_id_%0d_%0d", b, k), 64'(b_if.out_id), 64'(b % 4));
                chk($sformatf("t2_d_%0d_%0d", b, k), 64'(b_if.out_data), 64'(32'h100 + b % 4));
            end
            step();
            chk($sformatf("t2_bubble_%0d", b), 64'(b_if.out_valid), 0);
        end
        b_if.req_valid = '0;

        // 3: backpressure on requester 2
        drive_a(4'b0100, 4'b0000, pk(0, 0, 32'h10, 0));
        step();
        chk("t3_grant", 64'(a_if.req_ready), 64'(4'b0100));
        step();
        chk_a("t3_b1", 1, 32'h10, 2, 0);
        drive_a(4'b0100, 4'b0000, pk(0, 0, 32'h20, 0));
        a_if.out_ready = 1'b0;
        #1;
        chk("t3_stall_ready", 64'(a_if.req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_a($sformatf("t3_hold_%0d", k), 1, 32'h10, 2, 0);
            chk($sformatf("t3_hold_rdy_%0d", k), 64'(a_if.req_ready), 0);
        end
        a_if.out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(a_if.req_ready), 64'(4'b0100));
        step();
        chk_a("t3_b2", 1, 32'h20, 2, 0);
        drive_a(4'b0100, 4'b0100, pk(0, 0, 32'h30, 0));
        step();
        chk_a("t3_b3", 1, 32'h30, 2, 1);
        drive_a(4'b0, 4'b0, '0);
        step();
        chk_a("t3_drain", 0, 0, 0, 0);

        // 4: reset in the middle of a 4-beat burst from requester 3
        drive_a(4'b1000, 4'b0000, pk(0, 0, 0, 32'h1));
        step();
        chk("t4_grant", 64'(a_if.req_ready), 64'(4'b1000));
        step();
        chk_a("t4_b1", 1, 32'h1, 3, 0);
        drive_a(4'b1000, 4'b0000, pk(0, 0, 0, 32'h2));
        step();
        chk_a("t4_b2", 1, 32'h2, 3, 0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(a_if.out_valid), 0);
        chk("t4_rst_data",  64'(a_if.out_data),  0);
        chk("t4_rst_id",    64'(a_if.out_id),    0);
        chk("t4_rst_last",  64'(a_if.out_last),  0);
        chk("t4_rst_ready", 64'(a_if.req_ready), 0);
        chk("t4_rst_busy",  64'(a_if.busy),      0);
        drive_a(4'b1001, 4'b0001, pk(32'h7, 0, 0, 32'h3));
        rst_n = 1'b1;
        step();
        chk("t4_first_gnt", 64'(a_if.req_ready), 64'(4'b0001));
        drive_a(4'b0001, 4'b0001, pk(32'h7, 0, 0, 0));
        step();
        chk_a("t4_b0", 1, 32'h7, 0, 1);
        drive_a(4'b0, 4'b0, '0);
        step();
        chk_a("t4_drain", 0, 0, 0, 0);

        // 5: granted requester 2 stalls while requester 3 waits
        drive_a(4'b0100, 4'b0000, pk(0, 0, 32'h100, 0));
        step();
        chk("t5_grant", 64'(a_if.req_ready), 64'(4'b0100));
        step();
        chk_a("t5_b1", 1, 32'h100, 2, 0);
        drive_a(4'b1000, 4'b1000, pk(0, 0, 32'h200, 32'h333));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_keep_%0d", k), 64'(a_if.req_ready), 64'(4'b0100));
            chk($sformatf("t5_busy_%0d", k), 64'(a_if.busy), 1);
            chk_a($sformatf("t5_gap_%0d", k), 0, 0, 0, 0);
        end
        drive_a(4'b1100, 4'b1000, pk(0, 0, 32'h200, 32'h333));
        step();
        chk_a("t5_b2", 1, 32'h200, 2, 0);
        drive_a(4'b1100, 4'b1100, pk(0, 0, 32'h300, 32'h333));
        step();
        chk_a("t5_b3", 1, 32'h300, 2, 1);
        chk("t5_idle_ready", 64'(a_if.req_ready), 0);
        step();
        chk("t5_gnt3", 64'(a_if.req_ready), 64'(4'b1000));
        drive_a(4'b1000, 4'b1000, pk(0, 0, 0, 32'h333));
        step();
        chk_a("t5_r3", 1, 32'h333, 3, 1);
        drive_a(4'b0, 4'b0, '0);
        step();

        // 6: negative-slope handling
        drive_a(4'b0010, 4'b0000, pk(0, 32'hFFFF_FFF0, 0, 0));
        step();
        step();
`ifdef RELU_LEAKY_EN
        chk_a("t6_neg", 1, 32'hFFFF_FFFE, 1, 0);
`else
        chk_a("t6_neg", 1, 32'h0, 1, 0);
`endif
        drive_a(4'b0010, 4'b0010, pk(0, 32'h0000_0010, 0, 0));
        step();
        chk_a("t6_pos", 1, 32'h10, 1, 1);
        drive_a(4'b0, 4'b0, '0);
        step();
        chk_a("t6_drain", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
